// File: rtl/ibex_fetch_realign_fifo_pkg.sv
// Purpose: shared types and constants for the IF-stage fetch realignment FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: fetch_entry_t (one buffered fetch word plus its bus error), FETCH_WORD_BYTES.
package ibex_fetch_realign_fifo_pkg;

  // Bytes delivered per instruction-bus fetch response.
  localparam int unsigned FETCH_WORD_BYTES = 4;

  // One buffered fetch response.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/ibex_fetch_align_mux.sv
// Purpose: selects one compressed or 32-bit instruction from two consecutive fetch words.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides when the result is consumed.
// Ports: i_lo_* / i_hi_* are the word holding the current address and the following word,
//        i_addr1 is bit 1 of the current address; o_* carry the instruction, its validity,
//        fault attribution and the address increment (2 or 4).
module ibex_fetch_align_mux
  import ibex_fetch_realign_fifo_pkg::*;
(
  input  logic [31:0] i_lo_rdata,
  input  logic        i_lo_valid,
  input  logic        i_lo_err,
  input  logic [31:0] i_hi_rdata,
  input  logic        i_hi_valid,
  input  logic        i_hi_err,
  input  logic        i_addr1,
  output logic [31:0] o_instr,
  output logic        o_is_compressed,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_err_plus2,
  output logic [2:0]  o_addr_incr
);

  logic        w_straddle;
  logic [15:0] w_unused_hi_upper;

  // Only the low half of the following word can ever be part of an instruction.
  assign w_unused_hi_upper = i_hi_rdata[31:16];

  always_comb begin
    o_instr         = i_lo_rdata;
    o_is_compressed = 1'b0;
    o_valid         = 1'b0;
    o_err           = 1'b0;
    o_err_plus2     = 1'b0;
    w_straddle      = 1'b0;

    if (!i_addr1) begin
      // Whole instruction (16 or 32 bit) lives in lo.
      o_is_compressed = (i_lo_rdata[1:0] != 2'b11);
      o_valid         = i_lo_valid;
      o_err           = i_lo_err;
    end else begin
      o_is_compressed = (i_lo_rdata[17:16] != 2'b11);
      // A faulting lo word is reported at once without waiting for hi; its
      // data never depends on hi so it stays stable while stalled.
      w_straddle      = !o_is_compressed && !i_lo_err;
      if (w_straddle) begin
        o_instr     = {i_hi_rdata[15:0], i_lo_rdata[31:16]};
        o_valid     = i_lo_valid && i_hi_valid;
        o_err       = i_hi_err;
        o_err_plus2 = i_hi_err;
      end else begin
        o_instr = {16'h0000, i_lo_rdata[31:16]};
        o_valid = i_lo_valid;
        o_err   = i_lo_err;
      end
    end

    // Error flags are only meaningful alongside a valid instruction.
    o_err       = o_err & o_valid;
    o_err_plus2 = o_err_plus2 & o_valid;

    o_addr_incr = o_is_compressed ? 3'(FETCH_WORD_BYTES / 2) : 3'(FETCH_WORD_BYTES);
  end

endmodule

// File: rtl/ibex_fetch_realign_fifo.sv
// Purpose: buffers word-aligned fetch responses and hands out one realigned instruction per handshake.
// Latency: zero cycles when empty (input bypass), otherwise one cycle after a word is accepted.
// Backpressure: out_valid_o/out_ready_i on the output; no input backpressure, busy_o warns upstream instead.
// Ports: clk_i/rst_ni clock and async reset; clear_i/clear_addr_i flush and redirect;
//        in_valid_i/in_rdata_i/in_err_i fetch responses; busy_o fewer than two free entries;
//        out_valid_o/out_ready_i/out_rdata_o/out_addr_o/out_err_o/out_err_plus2_o aligned instruction.
module ibex_fetch_realign_fifo
  import ibex_fetch_realign_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        busy_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;

  fetch_entry_t  w_lo;
  fetch_entry_t  w_hi;
  logic          w_lo_vld;
  logic          w_hi_vld;
  logic [PW-1:0] w_rptr_nxt;
  logic          w_cnt_zero;
  logic          w_cnt_one;
  logic          w_full;
  logic          w_in_vld;
  logic          w_valid;
  logic          w_is_compressed;
  logic [2:0]    w_addr_incr;
  logic          w_accept;
  logic          w_pop_word;
  logic          w_fifo_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_unused_clear_addr0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_unused_clear_addr0 = clear_addr_i[0];

  assign w_rptr_nxt = ptr_inc(r_rptr);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_one  = (r_cnt == CW'(1));
  assign w_full     = (r_cnt == CW'(DEPTH));
  // A word arriving alongside a flush belongs to the old stream.
  assign w_in_vld   = in_valid_i && !clear_i;

  // lo is the word holding out_addr_o, hi the one after it. The incoming
  // word stands in for whichever of the two is not yet stored.
  always_comb begin
    w_lo     = r_mem[r_rptr];
    w_lo_vld = !w_cnt_zero;
    w_hi     = r_mem[w_rptr_nxt];
    w_hi_vld = !w_cnt_zero && !w_cnt_one;
    if (w_cnt_zero) begin
      w_lo.rdata = in_rdata_i;
      w_lo.err   = in_err_i;
      w_lo_vld   = w_in_vld;
      w_hi_vld   = 1'b0;
    end else if (w_cnt_one) begin
      w_hi.rdata = in_rdata_i;
      w_hi.err   = in_err_i;
      w_hi_vld   = w_in_vld;
    end
  end

  ibex_fetch_align_mux u_align_mux (
    .i_lo_rdata      (w_lo.rdata),
    .i_lo_valid      (w_lo_vld),
    .i_lo_err        (w_lo.err),
    .i_hi_rdata      (w_hi.rdata),
    .i_hi_valid      (w_hi_vld),
    .i_hi_err        (w_hi.err),
    .i_addr1         (r_addr[1]),
    .o_instr         (out_rdata_o),
    .o_is_compressed (w_is_compressed),
    .o_valid         (w_valid),
    .o_err           (out_err_o),
    .o_err_plus2     (out_err_plus2_o),
    .o_addr_incr     (w_addr_incr)
  );

  assign out_valid_o = w_valid;
  assign out_addr_o  = r_addr;
  assign busy_o      = (r_cnt > CW'(DEPTH - 2));

  assign w_accept   = w_valid && out_ready_i && !clear_i;
  // Leaving the current word: aligned 32-bit, or anything starting at addr[1]=1.
  assign w_pop_word = w_accept && (r_addr[1] || !w_is_compressed);
  assign w_fifo_pop = w_pop_word && !w_cnt_zero;
  // A bypassed word that is fully consumed in its arrival cycle is never stored.
  assign w_push_req = w_in_vld && !(w_cnt_zero && w_pop_word);
  assign w_push     = w_push_req && (!w_full || w_fifo_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      r_addr <= RESET_ADDR;
    end else if (clear_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      r_addr <= {clear_addr_i[31:1], 1'b0};
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_fifo_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_fifo_pop);
      if (w_accept) begin
        r_addr <= r_addr + {29'b0, w_addr_incr};
      end
    end
  end

  // Payload storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{rdata: in_rdata_i, err: in_err_i};
    end
  end

`ifndef SYNTHESIS
  a_out_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o |-> !$isunknown({out_rdata_o, out_addr_o, out_err_o, out_err_plus2_o}));
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push_req && w_full && !w_fifo_pop));
  a_addr_even : assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_addr_o[0] == 1'b0);
`endif

endmodule

// File: tb/tb_ibex_fetch_realign_fifo.sv
// Purpose: directed scoreboard bench for ibex_fetch_realign_fifo.
// Latency: checks same-cycle bypass and one-cycle buffered visibility.
// Backpressure: exercises stalls via out_ready_i and busy_o thresholds.
module tb_ibex_fetch_realign_fifo;

  localparam logic [31:0] RST_ADDR = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [31:0] clear_addr;
  logic        in_valid;
  logic [31:0] in_rdata;
  logic        in_err;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [31:0] out_addr;
  logic        out_err;
  logic        out_err_plus2;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] mask;
    logic [31:0] addr;
    logic        err;
    logic        plus2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;

  always #5 clk = ~clk;

  ibex_fetch_realign_fifo #(
    .DEPTH      (3),
    .RESET_ADDR (RST_ADDR)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .clear_addr_i    (clear_addr),
    .in_valid_i      (in_valid),
    .in_rdata_i      (in_rdata),
    .in_err_i        (in_err),
    .busy_o          (busy),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_rdata_o     (out_rdata),
    .out_addr_o      (out_addr),
    .out_err_o       (out_err),
    .out_err_plus2_o (out_err_plus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [31:0] d, input logic [31:0] m, input logic [31:0] a,
                            input logic e, input logic p2);
    sb.push_back('{rdata: d, mask: m, addr: a, err: e, plus2: p2});
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    in_valid = 1'b1;
    in_rdata = d;
    in_err   = e;
  endtask

  task automatic do_clear(input logic [31:0] a);
    clear      = 1'b1;
    clear_addr = a;
    in_valid   = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  // Monitor: every accepted instruction is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL out%0d unexpected: rdata %h addr %h, none required", n_out, out_rdata, out_addr);
      end else begin
        mon_e = sb.pop_front();
        if (((out_rdata & mon_e.mask) !== (mon_e.rdata & mon_e.mask)) || (out_addr !== mon_e.addr) ||
            (out_err !== mon_e.err) || (out_err_plus2 !== mon_e.plus2)) begin
          n_bad++;
          $display("FAIL out%0d: got rdata %h addr %h err %b p2 %b, required rdata %h (mask %h) addr %h err %b p2 %b",
                   n_out, out_rdata, out_addr, out_err, out_err_plus2,
                   mon_e.rdata, mon_e.mask, mon_e.addr, mon_e.err, mon_e.plus2);
        end
      end
      n_out++;
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL timeout: bench did not complete, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; clear_addr = '0;
    in_valid = 1'b0; in_rdata = '0; in_err = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_err", out_err, 0);
    chk("rst_plus2", out_err_plus2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", out_addr, RST_ADDR);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Aligned 32-bit word, bypassed in its arrival cycle.
    do_clear(32'h100);
    #1;
    chk("clr_addr", out_addr, 32'h100);
    chk("clr_valid", out_valid, 0);
    expect_out(32'h00B50513, 32'hFFFF_FFFF, 32'h100, 1'b0, 1'b0);
    out_ready = 1'b1;
    push(32'h00B50513, 1'b0);
    #1;
    chk("t1_bypass_vld", out_valid, 1);
    chk("t1_bypass_dat", out_rdata, 32'h00B50513);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_addr", out_addr, 32'h104);
    chk("t1_empty", out_valid, 0);

    // Two compressed instructions in one word.
    do_clear(32'h100);
    expect_out(32'h0000_4501, 32'h0000_FFFF, 32'h100, 1'b0, 1'b0);
    expect_out(32'h0000_4581, 32'h0000_FFFF, 32'h102, 1'b0, 1'b0);
    push(32'h45814501, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t2_addr_mid", out_addr, 32'h102);
    chk("t2_still_vld", out_valid, 1);
    tick();
    #1;
    chk("t2_addr_end", out_addr, 32'h104);
    chk("t2_empty", out_valid, 0);

    // Unaligned start with a straddling 32-bit instruction.
    do_clear(32'h102);
    expect_out(32'h00B50513, 32'hFFFF_FFFF, 32'h102, 1'b0, 1'b0);
    expect_out(32'h0000_0000, 32'h0000_FFFF, 32'h106, 1'b0, 1'b0);
    push(32'h05131234, 1'b0);
    #1;
    chk("t3_wait_hi", out_valid, 0);
    tick();
    push(32'h000000B5, 1'b0);
    #1;
    chk("t3_straddle_vld", out_valid, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t3_addr", out_addr, 32'h106);
    chk("t3_retained", out_valid, 1);
    tick();
    #1;
    chk("t3_addr_end", out_addr, 32'h108);
    chk("t3_empty", out_valid, 0);

    // Second-word fault on a straddling instruction, then the faulting word itself.
    do_clear(32'h202);
    expect_out(32'h00B50513, 32'hFFFF_FFFF, 32'h202, 1'b1, 1'b1);
    expect_out(32'h0000_0000, 32'h0000_FFFF, 32'h206, 1'b1, 1'b0);
    push(32'h05131234, 1'b0);
    tick();
    push(32'h000000B5, 1'b1);
    tick();
    in_valid = 1'b0;
    in_err   = 1'b0;
    tick();
    #1;
    chk("t4_empty", out_valid, 0);
    chk("t4_addr", out_addr, 32'h208);

    // First-word fault reported immediately, without the second word.
    do_clear(32'h302);
    expect_out(32'h0000_0513, 32'h0000_FFFF, 32'h302, 1'b1, 1'b0);
    push(32'h05131234, 1'b1);
    #1;
    chk("t4b_err_imm", out_valid, 1);
    tick();
    in_valid = 1'b0;
    in_err   = 1'b0;
    #1;
    chk("t4b_empty", out_valid, 0);

    // Fill under stall: busy threshold, hold stability, drain.
    do_clear(32'h400);
    out_ready = 1'b0;
    push(32'h00B50513, 1'b0);
    #1;
    chk("t5_busy_occ0", busy, 0);
    tick();
    push(32'h00C58593, 1'b0);
    #1;
    chk("t5_busy_occ1", busy, 0);
    tick();
    push(32'h45814501, 1'b0);
    #1;
    chk("t5_busy_occ2", busy, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t5_busy_full", busy, 1);
    chk("t5_hold_dat0", out_rdata, 32'h00B50513);
    chk("t5_hold_addr0", out_addr, 32'h400);
    tick();
    #1;
    chk("t5_hold_vld1", out_valid, 1);
    chk("t5_hold_dat1", out_rdata, 32'h00B50513);
    chk("t5_hold_addr1", out_addr, 32'h400);
    expect_out(32'h00B50513, 32'hFFFF_FFFF, 32'h400, 1'b0, 1'b0);
    expect_out(32'h00C58593, 32'hFFFF_FFFF, 32'h404, 1'b0, 1'b0);
    expect_out(32'h0000_4501, 32'h0000_FFFF, 32'h408, 1'b0, 1'b0);
    expect_out(32'h0000_4581, 32'h0000_FFFF, 32'h40A, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    #1;
    chk("t5_busy_occ2_after_pop", busy, 1);
    tick();
    #1;
    chk("t5_busy_occ1_after_pop", busy, 0);
    tick();
    tick();
    #1;
    chk("t5_empty", out_valid, 0);
    chk("t5_addr_end", out_addr, 32'h40C);

    // Flush with a concurrent push while non-empty.
    out_ready = 1'b0;
    push(32'h00B50513, 1'b0);
    tick();
    clear      = 1'b1;
    clear_addr = 32'h0000_0601;
    push(32'h11111111, 1'b0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6_valid_after_clr", out_valid, 0);
    chk("t6_addr_after_clr", out_addr, 32'h600);
    tick();
    #1;
    chk("t6_dropped_push", out_valid, 0);
    expect_out(32'h00C58593, 32'hFFFF_FFFF, 32'h600, 1'b0, 1'b0);
    out_ready = 1'b1;
    push(32'h00C58593, 1'b0);
    tick();
    in_valid = 1'b0;

    // Address wraps past the top of the address space.
    do_clear(32'hFFFF_FFFC);
    expect_out(32'h00B50513, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 1'b0);
    push(32'h00B50513, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t7_addr_wrap", out_addr, 32'h0);

    tick();
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
